// File: rtl/mips_sequencer.sv
// Multi-cycle control sequencer for the Mini-MIPS core: walks each instruction
// through FETCH/DECODE/EXECUTE/MEM/WB and owns run/halt, memory timeout and retire count.
module mips_sequencer #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_write_to_register,
    output logic             pc_write,
    output logic             rf_we,
    output logic [2:0]       state,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    localparam int WW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WW-1:0] LIMIT = WW'(WAIT_LIMIT);

    state_t          cur_state;
    state_t          nxt_state;
    logic [WW-1:0]   wait_cnt;
    logic            halt_pending;
    logic            retire;
    logic            timeout;

    // Memory handshake: a request is held high from its first cycle until the
    // cycle its ack is sampled high; the access completes in that ack cycle.
    // Acks seen in any other state are ignored.
    always_comb begin
        nxt_state = cur_state;
        retire    = 1'b0;
        timeout   = (WAIT_LIMIT != 0) && (wait_cnt == LIMIT);
        case (cur_state)
            S_IDLE:    if (start) nxt_state = S_FETCH;
            S_FETCH: begin
                if (imem_ack)     nxt_state = S_DECODE;
                else if (timeout) nxt_state = S_ERROR;
            end
            S_DECODE:  nxt_state = S_EXECUTE;
            S_EXECUTE: begin
                if (dec_load || dec_store)      nxt_state = S_MEM;
                else if (dec_write_to_register) nxt_state = S_WB;
                else                            retire    = 1'b1;
            end
            S_MEM: begin
                // Load and store together is treated as a store.
                if (dmem_ack) begin
                    if (dec_store) retire    = 1'b1;
                    else           nxt_state = S_WB;
                end else if (timeout) begin
                    nxt_state = S_ERROR;
                end
            end
            S_WB:      retire = 1'b1;
            S_HALT:    if (start) nxt_state = S_FETCH;
            S_ERROR:   nxt_state = S_ERROR;
            default:   nxt_state = S_IDLE;
        endcase
        // A halt_req landing in the retire cycle itself still stops here.
        if (retire) nxt_state = (halt_pending || halt_req) ? S_HALT : S_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= S_IDLE;
            wait_cnt     <= '0;
            halt_pending <= 1'b0;
            instr_count  <= '0;
        end else begin
            cur_state <= nxt_state;

            if ((nxt_state == S_FETCH && cur_state != S_FETCH) ||
                (nxt_state == S_MEM   && cur_state != S_MEM))
                wait_cnt <= '0;
            else if ((cur_state == S_FETCH && !imem_ack) ||
                     (cur_state == S_MEM   && !dmem_ack))
                wait_cnt <= wait_cnt + 1'b1;

            if (nxt_state == S_HALT)
                halt_pending <= 1'b0;
            else if (cur_state == S_HALT && start)
                halt_pending <= 1'b0;
            else if (busy && halt_req)
                halt_pending <= 1'b1;

            if (retire) instr_count <= instr_count + 1'b1;
        end
    end

    assign state    = cur_state;
    assign imem_req = (cur_state == S_FETCH);
    assign ir_load  = (cur_state == S_FETCH) && imem_ack;
    assign dmem_req = (cur_state == S_MEM);
    assign dmem_we  = (cur_state == S_MEM) && dec_store;
    assign rf_we    = (cur_state == S_WB);
    assign pc_write = retire;
    assign busy     = (cur_state >= S_FETCH) && (cur_state <= S_WB);
    assign error    = (cur_state == S_ERROR);

endmodule

// File: tb/tb_mips_sequencer.sv
// Directed bench for mips_sequencer: instruction classes, memory waits,
// halt/resume, timeout to ERROR, count wrap and mid-instruction reset.
module tb_mips_sequencer;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, halt_req;
    logic          imem_req, imem_ack, ir_load;
    logic          dmem_req, dmem_we, dmem_ack;
    logic          dec_load, dec_store, dec_wr;
    logic          pc_write, rf_we, busy, error;
    logic [2:0]    state;
    logic [CW-1:0] instr_count;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [CW-1:0] exp_count = '0;

    mips_sequencer #(.WAIT_LIMIT(15), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .dec_load(dec_load), .dec_store(dec_store),
        .dec_write_to_register(dec_wr),
        .pc_write(pc_write), .rf_we(rf_we), .state(state), .busy(busy),
        .error(error), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; halt_req = 0; imem_ack = 0; dmem_ack = 0;
        dec_load = 0; dec_store = 0; dec_wr = 0;
        #2;
        n_cmp++;
        if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++;
        if ({imem_req, ir_load, dmem_req, dmem_we, pc_write, rf_we, busy, error} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {imem_req, ir_load, dmem_req, dmem_we, pc_write, rf_we, busy, error});
        end
        n_cmp++;
        if (instr_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", instr_count); end
        next_cycle();
        rst_n = 1'b1;
        halt_req = 1'b1;
        next_cycle();
        n_cmp++;
        if (state !== 3'd0 || imem_req !== 1'b0) begin
            n_bad++; $display("FAIL idle_ignore_halt: got state %0d req %b want 0 0", state, imem_req);
        end
        halt_req = 1'b0;
    endtask

    task automatic test_rtype();
        logic [2:0] es [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        dec_load = 0; dec_store = 0; dec_wr = 1;
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 0);
            #1;
            n_cmp++;
            if (state !== es[i]) begin n_bad++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, es[i]); end
            n_cmp++;
            if ({imem_req, ir_load, rf_we, pc_write} !== {i == 0, i == 0, i == 3, i == 3}) begin
                n_bad++;
                $display("FAIL rtype_ctl[%0d]: got %b want %b", i, {imem_req, ir_load, rf_we, pc_write},
                         {i == 0, i == 0, i == 3, i == 3});
            end
            if (i == 3) exp_count++;
            next_cycle();
        end
        imem_ack = 0;
        n_cmp++;
        if (state !== 3'd1 || instr_count !== exp_count) begin
            n_bad++; $display("FAIL rtype_end: got state %0d count %0d want 1 %0d", state, instr_count, exp_count);
        end
    endtask

    task automatic test_load_wait();
        logic [2:0] es [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
        dec_load = 1; dec_store = 0; dec_wr = 1;
        for (int i = 0; i < 8; i++) begin
            imem_ack = (i == 0);
            dmem_ack = (i == 6);
            #1;
            n_cmp++;
            if (state !== es[i]) begin n_bad++; $display("FAIL load_state[%0d]: got %0d want %0d", i, state, es[i]); end
            n_cmp++;
            if ({dmem_req, dmem_we, rf_we, pc_write} !== {es[i] == 3'd4, 1'b0, i == 7, i == 7}) begin
                n_bad++;
                $display("FAIL load_ctl[%0d]: got %b want %b", i, {dmem_req, dmem_we, rf_we, pc_write},
                         {es[i] == 3'd4, 1'b0, i == 7, i == 7});
            end
            if (i == 7) exp_count++;
            next_cycle();
        end
        imem_ack = 0; dmem_ack = 0;
        n_cmp++;
        if (state !== 3'd1 || instr_count !== exp_count) begin
            n_bad++; $display("FAIL load_end: got state %0d count %0d want 1 %0d", state, instr_count, exp_count);
        end
    endtask

    task automatic test_store_branch();
        logic [2:0] es [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        dec_load = 0; dec_store = 1; dec_wr = 0;
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 0);
            dmem_ack = (i == 3);
            #1;
            n_cmp++;
            if (state !== es[i]) begin n_bad++; $display("FAIL store_state[%0d]: got %0d want %0d", i, state, es[i]); end
            n_cmp++;
            if ({dmem_req, dmem_we, rf_we, pc_write} !== {i == 3, i == 3, 1'b0, i == 3}) begin
                n_bad++;
                $display("FAIL store_ctl[%0d]: got %b want %b", i, {dmem_req, dmem_we, rf_we, pc_write},
                         {i == 3, i == 3, 1'b0, i == 3});
            end
            if (i == 3) exp_count++;
            next_cycle();
        end
        dmem_ack = 0;
        dec_store = 0;
        for (int i = 0; i < 3; i++) begin
            imem_ack = (i == 0);
            #1;
            n_cmp++;
            if (state !== 3'(i + 1) || pc_write !== (i == 2) || rf_we !== 1'b0) begin
                n_bad++;
                $display("FAIL branch[%0d]: got state %0d pcw %b rfwe %b want %0d %b 0",
                         i, state, pc_write, rf_we, i + 1, i == 2);
            end
            if (i == 2) exp_count++;
            next_cycle();
        end
        imem_ack = 0;
        n_cmp++;
        if (state !== 3'd1 || instr_count !== exp_count) begin
            n_bad++; $display("FAIL branch_end: got state %0d count %0d want 1 %0d", state, instr_count, exp_count);
        end
    endtask

    task automatic test_halt();
        logic [2:0] es [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
        dec_load = 0; dec_store = 0; dec_wr = 1;
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 0);
            halt_req = (i == 1);
            #1;
            n_cmp++;
            if (state !== es[i] || pc_write !== (i == 3)) begin
                n_bad++; $display("FAIL halt_run[%0d]: got state %0d pcw %b want %0d %b", i, state, pc_write, es[i], i == 3);
            end
            if (i == 3) exp_count++;
            next_cycle();
        end
        imem_ack = 0; halt_req = 0;
        for (int i = 0; i < 2; i++) begin
            imem_ack = 1'b1;
            #1;
            n_cmp++;
            if ({state, imem_req, pc_write, rf_we, busy} !== {3'd6, 4'b0000}) begin
                n_bad++;
                $display("FAIL halt_hold[%0d]: got %b want 1100000", i, {state, imem_req, pc_write, rf_we, busy});
            end
            next_cycle();
        end
        imem_ack = 0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        n_cmp++;
        if (state !== 3'd1) begin n_bad++; $display("FAIL halt_resume: got %0d want 1", state); end
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 0);
            halt_req = (i == 3);
            if (i == 3) exp_count++;
            next_cycle();
        end
        imem_ack = 0; halt_req = 0;
        n_cmp++;
        if (state !== 3'd6 || instr_count !== exp_count) begin
            n_bad++; $display("FAIL halt_boundary: got state %0d count %0d want 6 %0d", state, instr_count, exp_count);
        end
        start = 1'b1; halt_req = 1'b1;
        next_cycle();
        start = 1'b0; halt_req = 1'b0;
        dec_wr = 0;
        for (int i = 0; i < 3; i++) begin
            imem_ack = (i == 0);
            if (i == 2) exp_count++;
            next_cycle();
        end
        imem_ack = 0;
        n_cmp++;
        if (state !== 3'd1 || instr_count !== exp_count) begin
            n_bad++;
            $display("FAIL halt_start_clear: got state %0d count %0d want 1 %0d", state, instr_count, exp_count);
        end
    endtask

    task automatic test_timeout();
        dec_load = 0; dec_store = 0; dec_wr = 0;
        for (int i = 0; i < 16; i++) begin
            imem_ack = (i == 15);
            #1;
            n_cmp++;
            if (state !== 3'd1 || imem_req !== 1'b1 || ir_load !== (i == 15)) begin
                n_bad++;
                $display("FAIL late_ack[%0d]: got state %0d req %b ld %b want 1 1 %b", i, state, imem_req, ir_load, i == 15);
            end
            next_cycle();
        end
        imem_ack = 0;
        n_cmp++;
        if (state !== 3'd2) begin n_bad++; $display("FAIL late_ack_decode: got %0d want 2", state); end
        next_cycle();
        exp_count++;
        next_cycle();
        n_cmp++;
        if (state !== 3'd1 || instr_count !== exp_count) begin
            n_bad++; $display("FAIL count_wrap: got state %0d count %0d want 1 %0d", state, instr_count, exp_count);
        end
        for (int i = 0; i < 16; i++) next_cycle();
        start = 1'b1; imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({state, error, imem_req, busy, pc_write} !== {3'd7, 4'b1000}) begin
                n_bad++;
                $display("FAIL timeout_error[%0d]: got %b want 1111000", i, {state, error, imem_req, busy, pc_write});
            end
            next_cycle();
        end
        start = 1'b0; imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (error !== 1'b0 || state !== 3'd0) begin
            n_bad++; $display("FAIL error_reset: got err %b state %0d want 0 0", error, state);
        end
        next_cycle();
        rst_n = 1'b1;
        exp_count = '0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        dec_wr = 1;
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 0);
            if (i == 3) exp_count++;
            next_cycle();
        end
        dec_load = 1;
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 0);
            next_cycle();
        end
        imem_ack = 0;
        n_cmp++;
        if (state !== 3'd4 || dmem_req !== 1'b1 || instr_count !== exp_count) begin
            n_bad++;
            $display("FAIL mid_mem: got state %0d dreq %b count %0d want 4 1 %0d", state, dmem_req, instr_count, exp_count);
        end
        #2;
        dmem_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({state, imem_req, ir_load, dmem_req, dmem_we, pc_write, rf_we, busy, error} !== 11'h000) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %b want 00000000000",
                     {state, imem_req, ir_load, dmem_req, dmem_we, pc_write, rf_we, busy, error});
        end
        n_cmp++;
        if (instr_count !== '0) begin n_bad++; $display("FAIL mid_reset_count: got %0d want 0", instr_count); end
        dmem_ack = 1'b0;
        dec_load = 0; dec_wr = 0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store_branch();
        test_halt();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
